// File: rtl/contador_de_vagas_if.sv
// ----------------------------------------------------------------------------
// contador_de_vagas_if
// Bundles the sensor inputs, the clear request and the occupancy outputs of the
// parking-lot occupancy tracker. Member prefixes are written from the
// tracker's point of view: i_ members flow into it, o_ members flow out.
//
//   i_sensor_externo  external presence sensor, active-high, asynchronous
//   i_sensor_interno  internal presence sensor, active-high, asynchronous
//   i_zerar           synchronous clear of the count, active-high
//   o_ocupadas        occupied spaces
//   o_vagas_livres    capacity minus occupied spaces
//   o_cheio           high while the lot is full
//   o_entrou          1-cycle pulse when an entry is counted
//   o_saiu            1-cycle pulse when an exit is counted
//   o_erro_sequencia  1-cycle pulse on abort, underflow or overflow
//
// Modports: master drives sensors/clear (sensor front-end or bench),
//           slave is the tracker itself.
// ----------------------------------------------------------------------------
interface contador_de_vagas_if #(
    parameter int LARG = 8
);
    logic            i_sensor_externo;
    logic            i_sensor_interno;
    logic            i_zerar;
    logic [LARG-1:0] o_ocupadas;
    logic [LARG-1:0] o_vagas_livres;
    logic            o_cheio;
    logic            o_entrou;
    logic            o_saiu;
    logic            o_erro_sequencia;

    modport master (
        output i_sensor_externo,
        output i_sensor_interno,
        output i_zerar,
        input  o_ocupadas,
        input  o_vagas_livres,
        input  o_cheio,
        input  o_entrou,
        input  o_saiu,
        input  o_erro_sequencia
    );

    modport slave (
        input  i_sensor_externo,
        input  i_sensor_interno,
        input  i_zerar,
        output o_ocupadas,
        output o_vagas_livres,
        output o_cheio,
        output o_entrou,
        output o_saiu,
        output o_erro_sequencia
    );
endinterface

// File: rtl/contador_de_vagas.sv
// ----------------------------------------------------------------------------
// contador_de_vagas
// Occupancy tracker for the parking lot. Decodes vehicle direction from the
// order in which the external (e) and internal (i) presence sensors fire:
// 10 -> 11 -> 01 -> 00 is an entry, 01 -> 11 -> 10 -> 00 is an exit. Keeps the
// number of occupied spaces, raises o_cheio at capacity (feeds the gate
// controller's lot-full input) and flags illegal sequences / stuck sensors.
//
// Ports:
//   i_clk_760hz  system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   bus          contador_de_vagas_if.slave (sensors, clear, count, pulses)
//
// Parameters:
//   CAPACIDADE      number of spaces, 1..255
//   LARG            width of count outputs, CAPACIDADE <= 2^LARG-1
//   TIMEOUT_CICLOS  max consecutive cycles in a sequence step before abort
// ----------------------------------------------------------------------------
module contador_de_vagas #(
    parameter int CAPACIDADE     = 20,
    parameter int LARG           = 8,
    parameter int TIMEOUT_CICLOS = 7600
) (
    input  logic                 i_clk_760hz,
    input  logic                 i_reset_n,
    contador_de_vagas_if.slave   bus
);

    localparam int              TW      = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [LARG-1:0] CAP     = LARG'(CAPACIDADE);
    localparam logic [TW-1:0]   TMR_MAX = TW'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        E1,
        E2,
        E3,
        S1,
        S2,
        S3,
        ESPERA_LIVRE
    } estado_t;

    estado_t         r_estado;
    estado_t         w_proxEstado;
    logic [TW-1:0]   r_timer;

    logic            r_extMeta;
    logic            r_extSync;
    logic            r_intMeta;
    logic            r_intSync;
    logic [1:0]      w_par;

    logic [LARG-1:0] r_ocupadas;
    logic [LARG-1:0] r_vagasLivres;
    logic            r_cheio;
    logic            r_entrou;
    logic            r_saiu;
    logic            r_erroSequencia;

    logic            w_completaEntrada;
    logic            w_completaSaida;
    logic            w_erroFsm;
    logic            w_estadoAtivo;
    logic [LARG-1:0] w_ocupadasProx;
    logic            w_entrouProx;
    logic            w_saiuProx;
    logic            w_erroConta;

    // Two-flop synchronizers: the sensors are asynchronous to the clock, so
    // the FSM only ever looks at the second stage of each chain.
    always_ff @(posedge i_clk_760hz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_extMeta <= 1'b0;
            r_extSync <= 1'b0;
            r_intMeta <= 1'b0;
            r_intSync <= 1'b0;
        end else begin
            r_extMeta <= bus.i_sensor_externo;
            r_extSync <= r_extMeta;
            r_intMeta <= bus.i_sensor_interno;
            r_intSync <= r_intMeta;
        end
    end

    assign w_par         = {r_extSync, r_intSync};
    assign w_estadoAtivo = (r_estado != OCIOSO) && (r_estado != ESPERA_LIVRE);

    // Sequence decoder. Each sequence step accepts its own pattern (hold),
    // the next pattern (advance) or the previous one (vehicle rocking back);
    // anything else parks the FSM in ESPERA_LIVRE until the sensors clear.
    // A step held for TIMEOUT_CICLOS cycles is treated as a stuck sensor.
    always_comb begin
        w_proxEstado      = r_estado;
        w_completaEntrada = 1'b0;
        w_completaSaida   = 1'b0;
        w_erroFsm         = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (w_par == 2'b10)      w_proxEstado = E1;
                else if (w_par == 2'b01) w_proxEstado = S1;
                else if (w_par == 2'b11) w_proxEstado = ESPERA_LIVRE;
            end
            E1: begin
                if (w_par == 2'b11)      w_proxEstado = E2;
                else if (w_par == 2'b00) w_proxEstado = OCIOSO;
                else if (w_par == 2'b01) w_proxEstado = ESPERA_LIVRE;
            end
            E2: begin
                if (w_par == 2'b01)      w_proxEstado = E3;
                else if (w_par == 2'b10) w_proxEstado = E1;
                else if (w_par == 2'b00) w_proxEstado = ESPERA_LIVRE;
            end
            E3: begin
                if (w_par == 2'b00) begin
                    w_proxEstado      = OCIOSO;
                    w_completaEntrada = 1'b1;
                end
                else if (w_par == 2'b11) w_proxEstado = E2;
                else if (w_par == 2'b10) w_proxEstado = ESPERA_LIVRE;
            end
            S1: begin
                if (w_par == 2'b11)      w_proxEstado = S2;
                else if (w_par == 2'b00) w_proxEstado = OCIOSO;
                else if (w_par == 2'b10) w_proxEstado = ESPERA_LIVRE;
            end
            S2: begin
                if (w_par == 2'b10)      w_proxEstado = S3;
                else if (w_par == 2'b01) w_proxEstado = S1;
                else if (w_par == 2'b00) w_proxEstado = ESPERA_LIVRE;
            end
            S3: begin
                if (w_par == 2'b00) begin
                    w_proxEstado    = OCIOSO;
                    w_completaSaida = 1'b1;
                end
                else if (w_par == 2'b11) w_proxEstado = S2;
                else if (w_par == 2'b01) w_proxEstado = ESPERA_LIVRE;
            end
            ESPERA_LIVRE: begin
                if (w_par == 2'b00) w_proxEstado = OCIOSO;
            end
            default: w_proxEstado = OCIOSO;
        endcase

        // Timeout only fires when the decoder wants to stay put, so a
        // completion can never be lost to it.
        if (w_estadoAtivo && (w_proxEstado == r_estado) && (r_timer == TMR_MAX)) begin
            w_proxEstado = ESPERA_LIVRE;
        end

        w_erroFsm = (w_proxEstado == ESPERA_LIVRE) && (r_estado != ESPERA_LIVRE);
    end

    // State register and dwell timer; the timer restarts on every state
    // change and only runs inside an entry/exit sequence.
    always_ff @(posedge i_clk_760hz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_estado <= OCIOSO;
            r_timer  <= '0;
        end else begin
            r_estado <= w_proxEstado;
            if (w_proxEstado != r_estado) begin
                r_timer <= '0;
            end else if (w_estadoAtivo) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    // Next count. Clear wins over a completion on the same edge and swallows
    // its pulse; saturation at 0 and CAPACIDADE turns the would-be wrap into
    // an error pulse instead.
    always_comb begin
        w_ocupadasProx = r_ocupadas;
        w_entrouProx   = 1'b0;
        w_saiuProx     = 1'b0;
        w_erroConta    = 1'b0;
        if (bus.i_zerar) begin
            w_ocupadasProx = '0;
        end else if (w_completaEntrada) begin
            if (r_ocupadas < CAP) begin
                w_ocupadasProx = r_ocupadas + LARG'(1);
                w_entrouProx   = 1'b1;
            end else begin
                w_erroConta = 1'b1;
            end
        end else if (w_completaSaida) begin
            if (r_ocupadas != '0) begin
                w_ocupadasProx = r_ocupadas - LARG'(1);
                w_saiuProx     = 1'b1;
            end else begin
                w_erroConta = 1'b1;
            end
        end
    end

    // Output registers. Free spaces and the full flag are derived from the
    // next count so all three move together on the same edge.
    always_ff @(posedge i_clk_760hz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ocupadas      <= '0;
            r_vagasLivres   <= CAP;
            r_cheio         <= 1'b0;
            r_entrou        <= 1'b0;
            r_saiu          <= 1'b0;
            r_erroSequencia <= 1'b0;
        end else begin
            r_ocupadas      <= w_ocupadasProx;
            r_vagasLivres   <= CAP - w_ocupadasProx;
            r_cheio         <= (w_ocupadasProx == CAP);
            r_entrou        <= w_entrouProx;
            r_saiu          <= w_saiuProx;
            r_erroSequencia <= w_erroFsm | w_erroConta;
        end
    end

    assign bus.o_ocupadas       = r_ocupadas;
    assign bus.o_vagas_livres   = r_vagasLivres;
    assign bus.o_cheio          = r_cheio;
    assign bus.o_entrou         = r_entrou;
    assign bus.o_saiu           = r_saiu;
    assign bus.o_erro_sequencia = r_erroSequencia;

endmodule

// File: tb/tb_contador_de_vagas.sv
// ----------------------------------------------------------------------------
// tb_contador_de_vagas
// Drives contador_de_vagas through directed entry/exit/abort/timeout/clear/
// reset scenarios followed by a randomized sensor walk, and compares every
// output on every cycle against a behavioural model of the parking lot.
// ----------------------------------------------------------------------------
module tb_contador_de_vagas;

    localparam int CAP  = 20;
    localparam int LARG = 8;
    localparam int TOUT = 7600;

    localparam int IDLE  = 0;
    localparam int ENTRA = 1;
    localparam int SAI   = 2;
    localparam int WAITC = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int nTests = 0;
    int nFail  = 0;

    // Model state: what the lot looks like, which direction a vehicle is
    // travelling and how far along its route it is.
    int         mCount;
    int         mMode;
    int         mProg;
    int         mDwell;
    logic       mEnt;
    logic       mSai;
    logic       mErro;
    logic [1:0] mPipe[$];

    always #5 clk = ~clk;

    contador_de_vagas_if #(.LARG(LARG)) bus ();

    contador_de_vagas #(
        .CAPACIDADE     (CAP),
        .LARG           (LARG),
        .TIMEOUT_CICLOS (TOUT)
    ) dut (
        .i_clk_760hz (clk),
        .i_reset_n   (rst_n),
        .bus         (bus)
    );

    // Route of an entering vehicle as {e,i}; exits use the same route with
    // the two sensors swapped.
    function automatic logic [1:0] rota(input int k);
        case (k)
            0:       rota = 2'b10;
            1:       rota = 2'b11;
            default: rota = 2'b01;
        endcase
    endfunction

    task automatic modelReset();
        mCount = 0;
        mMode  = IDLE;
        mProg  = 0;
        mDwell = 0;
        mEnt   = 1'b0;
        mSai   = 1'b0;
        mErro  = 1'b0;
        mPipe  = {2'b00, 2'b00};
    endtask

    // One clock edge of the lot. Sensor samples reach the decision logic two
    // samples late, which the queue models directly.
    task automatic modelEdge(input logic e, input logic i, input logic z);
        logic [1:0] par;
        logic [1:0] q;
        int         oldMode;
        int         oldProg;
        bit         completa;
        par = mPipe.pop_front();
        mPipe.push_back({e, i});
        mEnt     = 1'b0;
        mSai     = 1'b0;
        mErro    = 1'b0;
        completa = 1'b0;
        oldMode  = mMode;
        oldProg  = mProg;
        if (mMode == IDLE) begin
            if (par == 2'b10) begin
                mMode = ENTRA;
                mProg = 0;
            end else if (par == 2'b01) begin
                mMode = SAI;
                mProg = 0;
            end else if (par == 2'b11) begin
                mMode = WAITC;
            end
        end else if (mMode == WAITC) begin
            if (par == 2'b00) mMode = IDLE;
        end else begin
            q = (mMode == ENTRA) ? par : {par[0], par[1]};
            if (q == rota(mProg)) begin
                mProg = mProg;
            end else if (mProg < 2 && q == rota(mProg + 1)) begin
                mProg = mProg + 1;
            end else if (mProg > 0 && q == rota(mProg - 1)) begin
                mProg = mProg - 1;
            end else if (q == 2'b00 && mProg == 2) begin
                completa = 1'b1;
                mMode    = IDLE;
            end else if (q == 2'b00 && mProg == 0) begin
                mMode = IDLE;
            end else begin
                mMode = WAITC;
            end
        end
        if (mMode == oldMode && mProg == oldProg && (oldMode == ENTRA || oldMode == SAI)) begin
            if (mDwell == TOUT - 1) begin
                mMode  = WAITC;
                mDwell = 0;
            end else begin
                mDwell = mDwell + 1;
            end
        end else begin
            mDwell = 0;
        end
        if (mMode == WAITC && oldMode != WAITC) mErro = 1'b1;
        if (z) begin
            mCount = 0;
        end else if (completa && oldMode == ENTRA) begin
            if (mCount < CAP) begin
                mCount = mCount + 1;
                mEnt   = 1'b1;
            end else begin
                mErro = 1'b1;
            end
        end else if (completa) begin
            if (mCount > 0) begin
                mCount = mCount - 1;
                mSai   = 1'b1;
            end else begin
                mErro = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("ocupadas",       32'(bus.o_ocupadas),       32'(mCount));
        check("vagas_livres",   32'(bus.o_vagas_livres),   32'(CAP - mCount));
        check("cheio",          32'(bus.o_cheio),          32'(mCount == CAP));
        check("entrou",         32'(bus.o_entrou),         32'(mEnt));
        check("saiu",           32'(bus.o_saiu),           32'(mSai));
        check("erro_sequencia", 32'(bus.o_erro_sequencia), 32'(mErro));
    endtask

    // Hold one input pattern for n cycles, checking after every edge.
    task automatic applyStimulus(input logic e, input logic i, input logic z, input int n);
        for (int k = 0; k < n; k++) begin
            bus.i_sensor_externo = e;
            bus.i_sensor_interno = i;
            bus.i_zerar          = z;
            @(posedge clk);
            modelEdge(e, i, z);
            #1;
            checkOutput();
        end
    endtask

    task automatic doEntry(input int h);
        applyStimulus(1'b1, 1'b0, 1'b0, h);
        applyStimulus(1'b1, 1'b1, 1'b0, h);
        applyStimulus(1'b0, 1'b1, 1'b0, h);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
    endtask

    task automatic doExit(input int h);
        applyStimulus(1'b0, 1'b1, 1'b0, h);
        applyStimulus(1'b1, 1'b1, 1'b0, h);
        applyStimulus(1'b1, 1'b0, 1'b0, h);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
    endtask

    // Asserts reset between edges and checks that outputs clear at once.
    task automatic asyncReset();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        bus.i_sensor_externo = 1'b0;
        bus.i_sensor_interno = 1'b0;
        bus.i_zerar          = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int  sel;
        logic [1:0] rp;

        bus.i_sensor_externo = 1'b0;
        bus.i_sensor_interno = 1'b0;
        bus.i_zerar          = 1'b0;
        modelReset();
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput();
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3);

        $display("[TB] single entry");
        doEntry(5);

        $display("[TB] fill to capacity, then overflow");
        for (int n = 0; n < 19; n++) doEntry($urandom_range(1, 4));
        doEntry(3);

        $display("[TB] underflow exit, then a real exit");
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        doExit(3);
        doEntry(2);
        doExit(4);

        $display("[TB] backout, illegal sequence, stuck sensor");
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 6);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, TOUT + 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 4);

        $display("[TB] clear coincident with entry completion at 7");
        for (int n = 0; n < 7; n++) doEntry(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3);

        $display("[TB] reset in the middle of an entry");
        doEntry(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 4);
        asyncReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        doEntry(3);

        $display("[TB] randomized sensor walk");
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                doEntry($urandom_range(1, 5));
            end else if (sel == 1) begin
                doExit($urandom_range(1, 5));
            end else begin
                rp = 2'($urandom_range(0, 3));
                applyStimulus(rp[1], rp[0], ($urandom_range(0, 40) == 0), $urandom_range(1, 6));
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 5);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
